// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: single-outstanding memory fetch into a small instruction FIFO.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-stall counter output.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_out,
  input  logic        inst_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  entry_t        fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          push, pop, credit;
  logic [31:0]   pc_plus4, redir_pc;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign pc_plus4    = fetch_pc + 32'd4;
  assign redir_pc    = {redirect_pc[31:2], 2'b00};

  // Redirect overrides both ends of the FIFO: nothing is pushed or popped that cycle.
  assign inst_valid = (cnt != '0);
  assign pop        = inst_valid & inst_ready & ~redirect;
  assign push       = (state == S_REQ) & mem_ack & ~redirect;
  assign cnt_nxt    = cnt + CW'(push) - CW'(pop);
  // Once the ack lands nothing is outstanding, so occupancy after this edge is the whole budget.
  assign credit     = (cnt_nxt < DEPTH_C);

  assign inst_pc  = inst_valid ? fifo_q[rd_ptr].pc   : '0;
  assign inst_out = inst_valid ? fifo_q[rd_ptr].inst : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
          end else if (credit) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
            if (mem_ack) begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end else begin
              state <= S_DISCARD;
            end
          end else if (mem_ack) begin
            fetch_pc <= pc_plus4;
            if (credit) begin
              mem_addr <= pc_plus4;
            end else begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          // Stale request stays on the bus untouched until memory accepts it.
          if (redirect) fetch_pc <= redir_pc;
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nxt;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: fetch_pc, inst: mem_rdata};
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (inst_ready && !inst_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: streaming, back-pressure, redirects, reset, PC wrap.
module tb_fetch_prefetch_unit;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, inst_pc, inst_out;
  logic        mem_req_b, mem_ack_b, redirect_b, inst_valid_b, inst_ready_b;
  logic [31:0] mem_addr_b, mem_rdata_b, redirect_pc_b, inst_pc_b, inst_out_b;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  // Memory returns a word derived from the requested address.
  assign mem_rdata   = mem_addr ^ K;
  assign mem_rdata_b = mem_addr_b ^ K;

  fetch_prefetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_out(inst_out), .inst_ready(inst_ready));

  fetch_prefetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack_b),
    .mem_rdata(mem_rdata_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt_b),
`endif
    .inst_valid(inst_valid_b), .inst_pc(inst_pc_b), .inst_out(inst_out_b), .inst_ready(inst_ready_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    mem_ack_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0; inst_ready_b = 1'b1;
    #2 rst = 1'b0;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_wrap_addr", mem_addr_b, 32'hFFFF_FFFC);

`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b1; inst_ready = 1'b1;
    repeat (5) step();
    chk("stall_cnt_5", stall_cnt, 32'd5);
    chk("stall_req_held", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("stall_rst_req", {31'd0, mem_req}, 32'd0);
    inst_ready = 1'b0;
    step();
`endif

    // Streaming from reset with ack every request cycle and decode always ready.
    rst = 1'b1; inst_ready = 1'b1; mem_ack = 1'b0;
    step();
    chk("s1_req", {31'd0, mem_req}, 32'd1);
    chk("s1_addr", mem_addr, 32'h0);
    chk("w1_req", {31'd0, mem_req_b}, 32'd1);
    chk("w1_addr", mem_addr_b, 32'hFFFF_FFFC);
    mem_ack = 1'b1;
    step();
    chk("s2_addr", mem_addr, 32'h4);
    chk("s2_valid", {31'd0, inst_valid}, 32'd1);
    chk("s2_pc", inst_pc, 32'h0);
    chk("s2_inst", inst_out, 32'hDEAD_0000);
    chk("w2_addr_wrap", mem_addr_b, 32'h0);
    chk("w2_pc", inst_pc_b, 32'hFFFF_FFFC);
    step();
    chk("s3_addr", mem_addr, 32'h8);
    chk("s3_pc", inst_pc, 32'h4);
    step();
    chk("s4_addr", mem_addr, 32'hC);
    chk("s4_pc", inst_pc, 32'h8);

    // Asynchronous reset mid-stream takes effect without a clock edge.
    rst = 1'b0;
    #1;
    chk("ar_req", {31'd0, mem_req}, 32'd0);
    chk("ar_valid", {31'd0, inst_valid}, 32'd0);
    step();

    // Back-pressure: decode stalled, only FIFO_DEPTH fetches are accepted.
    rst = 1'b1; inst_ready = 1'b0; mem_ack = 1'b1;
    step();
    chk("bp1_req", {31'd0, mem_req}, 32'd1);
    chk("bp1_addr", mem_addr, 32'h0);
    step();
    chk("bp2_addr", mem_addr, 32'h4);
    chk("bp2_valid", {31'd0, inst_valid}, 32'd1);
    chk("bp2_pc", inst_pc, 32'h0);
    step();
    chk("bp3_req", {31'd0, mem_req}, 32'd0);
    chk("bp3_pc", inst_pc, 32'h0);
    step();
    chk("bp4_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0; inst_ready = 1'b1;
    step();
    chk("bp5_req", {31'd0, mem_req}, 32'd1);
    chk("bp5_addr", mem_addr, 32'h8);
    chk("bp5_pc", inst_pc, 32'h4);
    inst_ready = 1'b0;
    step();
    chk("bp6_req", {31'd0, mem_req}, 32'd1);
    chk("bp6_addr", mem_addr, 32'h8);
    chk("bp6_pc", inst_pc, 32'h4);

    // Redirect with the request unacked: stale fetch is held, then dropped.
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    chk("dis1_req", {31'd0, mem_req}, 32'd1);
    chk("dis1_addr", mem_addr, 32'h8);
    chk("dis1_valid", {31'd0, inst_valid}, 32'd0);
    redirect = 1'b0;
    step();
    chk("dis2_req", {31'd0, mem_req}, 32'd1);
    chk("dis2_addr", mem_addr, 32'h8);
    chk("dis2_valid", {31'd0, inst_valid}, 32'd0);
    mem_ack = 1'b1;
    step();
    chk("dis3_req", {31'd0, mem_req}, 32'd0);
    chk("dis3_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("rd1_req", {31'd0, mem_req}, 32'd1);
    chk("rd1_addr", mem_addr, 32'h100);
    chk("rd1_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("rd2_addr", mem_addr, 32'h104);
    chk("rd2_valid", {31'd0, inst_valid}, 32'd1);
    chk("rd2_pc", inst_pc, 32'h100);
    chk("rd2_inst", inst_out, 32'hDEAD_0100);

    // Redirect coinciding with ack: returned word never reaches decode.
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    chk("ra1_req", {31'd0, mem_req}, 32'd0);
    chk("ra1_valid", {31'd0, inst_valid}, 32'd0);
    redirect = 1'b0; mem_ack = 1'b0; inst_ready = 1'b1;
    step();
    chk("ra2_req", {31'd0, mem_req}, 32'd1);
    chk("ra2_addr", mem_addr, 32'h200);
    chk("ra2_valid", {31'd0, inst_valid}, 32'd0);
    mem_ack = 1'b1;
    step();
    chk("ra3_valid", {31'd0, inst_valid}, 32'd1);
    chk("ra3_pc", inst_pc, 32'h200);
    chk("ra3_addr", mem_addr, 32'h204);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
